// File: rtl/uart_frame_writer.sv
// Buffers (address, pixel) pairs from the UART receiver in a small FIFO and
// streams them to the frame-buffer RAM over a ready/valid write port.
module uart_frame_writer #(
    parameter int AW         = 21,
    parameter int DW         = 16,
    parameter int DEPTH      = 4,
    parameter int FRAME_LAST = 307199
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] address_ram,
    input  logic [DW-1:0] data,
    input  logic          dataflag,
    input  logic          ram_ready,
    input  logic          count_clr,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          frame_done,
    output logic          overflow,
    output logic [AW-1:0] write_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_LAST);

    logic [0:0]    state;
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;

    logic empty;
    logic full;
    logic accept;
    logic pop;
    logic push;
    logic drop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign ram_we = (state == S_WRITE);
    assign accept = ram_we && ram_ready;
    // The output register refills whenever it is free or being released this edge.
    assign pop    = !empty && (!ram_we || accept);
    assign push   = dataflag && (!full || pop);
    assign drop   = dataflag && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[PW-1:0]] <= address_ram;
            fifo_data[wr_ptr[PW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            if (pop) begin
                ram_addr  <= fifo_addr[rd_ptr[PW-1:0]];
                ram_wdata <= fifo_data[rd_ptr[PW-1:0]];
            end
            case (state)
                S_IDLE:  if (pop) state <= S_WRITE;
                S_WRITE: if (accept && !pop) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            write_count <= '0;
        end else begin
            frame_done <= accept && (ram_addr == LAST_ADDR);
            // Clear wins over both a same-edge accept and a same-edge drop.
            if (count_clr) begin
                write_count <= '0;
                overflow    <= 1'b0;
            end else begin
                if (accept) begin
                    write_count <= write_count + {{(AW-1){1'b0}}, 1'b1};
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_writer.sv
// Directed bench for uart_frame_writer: a queue-based reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_uart_frame_writer;

    localparam int AW         = 21;
    localparam int DW         = 16;
    localparam int DEPTH      = 4;
    localparam int FRAME_LAST = 307199;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] address_ram = '0;
    logic [DW-1:0] data = '0;
    logic          dataflag = 1'b0;
    logic          ram_ready = 1'b0;
    logic          count_clr = 1'b0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          frame_done;
    logic          overflow;
    logic [AW-1:0] write_count;

    always #5 clk = ~clk;

    uart_frame_writer #(
        .AW(AW), .DW(DW), .DEPTH(DEPTH), .FRAME_LAST(FRAME_LAST)
    ) dut (
        .clk(clk), .rst(rst), .address_ram(address_ram), .data(data),
        .dataflag(dataflag), .ram_ready(ram_ready), .count_clr(count_clr),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .frame_done(frame_done), .overflow(overflow), .write_count(write_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: a pending queue plus one "presented" slot.
    logic [AW-1:0] mq_a [$];
    logic [DW-1:0] mq_d [$];
    bit            m_v   = 1'b0;
    logic [AW-1:0] m_a   = '0;
    logic [DW-1:0] m_d   = '0;
    bit            m_fd  = 1'b0;
    bit            m_ovf = 1'b0;
    logic [AW-1:0] m_cnt = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq_a.delete();
                mq_d.delete();
                m_v = 0; m_a = '0; m_d = '0; m_fd = 0; m_ovf = 0; m_cnt = '0;
            end else begin
                bit acc, pop, ok;
                int sz;
                acc = m_v && ram_ready;
                sz  = mq_a.size();
                pop = (sz > 0) && (!m_v || acc);
                ok  = dataflag && (sz < DEPTH || pop);
                m_fd = acc && (int'(m_a) == FRAME_LAST);
                if (count_clr) begin
                    m_cnt = '0;
                    m_ovf = 0;
                end else begin
                    if (acc) m_cnt = m_cnt + 1'b1;
                    if (dataflag && !ok) m_ovf = 1;
                end
                if (pop) begin
                    m_a = mq_a.pop_front();
                    m_d = mq_d.pop_front();
                    m_v = 1;
                end else if (acc) begin
                    m_v = 0;
                end
                if (ok) begin
                    mq_a.push_back(address_ram);
                    mq_d.push_back(data);
                end
            end
        end
    end

    // Per-cycle comparison, plus a log of addresses the DUT gets accepted.
    logic [AW-1:0] dut_log [$];

    initial begin
        forever begin
            @(negedge clk);
            chk("ram_we",      32'(ram_we),      32'(m_v));
            chk("ram_addr",    32'(ram_addr),    32'(m_a));
            chk("ram_wdata",   32'(ram_wdata),   32'(m_d));
            chk("frame_done",  32'(frame_done),  32'(m_fd));
            chk("overflow",    32'(overflow),    32'(m_ovf));
            chk("write_count", 32'(write_count), 32'(m_cnt));
            if (rst && ram_we && ram_ready) dut_log.push_back(ram_addr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        address_ram = a;
        data        = d;
        dataflag    = 1'b1;
        tick();
        dataflag    = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_we", 32'(ram_we), 0);
        chk("rst_count", 32'(write_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst = 1'b1;
        tick();

        // Single write, two-clock latency
        ram_ready = 1'b1;
        push(21'd5, 16'hABCD);
        chk("t1_we_early", 32'(ram_we), 0);
        tick();
        chk("t1_we", 32'(ram_we), 1);
        chk("t1_addr", 32'(ram_addr), 5);
        chk("t1_data", 32'(ram_wdata), 32'hABCD);
        tick();
        chk("t1_we_drop", 32'(ram_we), 0);
        chk("t1_count", 32'(write_count), 1);
        chk("t1_ovf", 32'(overflow), 0);

        // Overflow after DEPTH+1 held, then in-order drain
        ram_ready = 1'b0;
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        for (int i = 0; i < 6; i++) push(AW'(i), DW'(16'h0100 + i));
        chk("t2_ovf", 32'(overflow), 1);
        chk("t2_we", 32'(ram_we), 1);
        chk("t2_head", 32'(ram_addr), 0);
        dut_log.delete();
        ram_ready = 1'b1;
        repeat (5) tick();
        chk("t2_nwrites", 32'(dut_log.size()), 5);
        for (int i = 0; i < 5 && i < dut_log.size(); i++) chk("t2_order", 32'(dut_log[i]), 32'(i));
        chk("t2_count", 32'(write_count), 5);
        chk("t2_idle", 32'(ram_we), 0);

        // frame_done on the last pixel only
        push(AW'(FRAME_LAST), 16'h0001);
        tick();
        chk("t3_fd_pre", 32'(frame_done), 0);
        tick();
        chk("t3_fd", 32'(frame_done), 1);
        tick();
        chk("t3_fd_once", 32'(frame_done), 0);
        push(AW'(FRAME_LAST - 1), 16'h0002);
        tick();
        tick();
        chk("t3_fd_none", 32'(frame_done), 0);
        tick();
        chk("t3_fd_none2", 32'(frame_done), 0);

        // Full buffer, push coinciding with a pop is kept
        count_clr = 1'b1;
        ram_ready = 1'b0;
        tick();
        count_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 0);
        for (int i = 0; i < 5; i++) push(AW'(10 + i), DW'(16'h1000 + i));
        chk("t4_ovf_full", 32'(overflow), 0);
        chk("t4_we", 32'(ram_we), 1);
        dut_log.delete();
        ram_ready = 1'b1;
        push(21'd9, 16'h0909);
        ram_ready = 1'b0;
        chk("t4_ovf_pop", 32'(overflow), 0);
        tick();
        ram_ready = 1'b1;
        repeat (7) tick();
        chk("t4_ovf_end", 32'(overflow), 0);
        chk("t4_nwrites", 32'(dut_log.size()), 6);
        if (dut_log.size() == 6) begin
            chk("t4_first", 32'(dut_log[0]), 10);
            chk("t4_last", 32'(dut_log[5]), 9);
        end

        // Async reset mid-write discards everything
        ram_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(AW'(20 + i), DW'(16'h2000 + i));
        chk("t5_we_before", 32'(ram_we), 1);
        chk("t5_addr_before", 32'(ram_addr), 20);
        dut_log.delete();
        rst = 1'b0;
        #1;
        chk("t5_we_now", 32'(ram_we), 0);
        chk("t5_count_now", 32'(write_count), 0);
        tick();
        tick();
        rst = 1'b1;
        ram_ready = 1'b1;
        repeat (4) tick();
        chk("t5_quiet_we", 32'(ram_we), 0);
        chk("t5_quiet_log", 32'(dut_log.size()), 0);
        push(21'd30, 16'h3030);
        tick();
        chk("t5_new_we", 32'(ram_we), 1);
        chk("t5_new_addr", 32'(ram_addr), 30);
        tick();
        chk("t5_new_log", 32'(dut_log.size()), 1);

        // Clear beats a same-edge accept
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        for (int i = 0; i < 8; i++) push(AW'(40 + i), DW'(16'h4000 + i));
        tick();
        chk("t6_count7", 32'(write_count), 7);
        chk("t6_we", 32'(ram_we), 1);
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        chk("t6_count0", 32'(write_count), 0);
        chk("t6_ovf0", 32'(overflow), 0);
        chk("t6_idle", 32'(ram_we), 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
